// File: rtl/memory_access_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : memory_access_scheduler
// Purpose  : Shares BlockMemoryStorage between a write stream and an inquiry
//            port. Runs a clear sequence and then arbitrates store/inquire
//            traffic. Writes win by default, and a starvation counter
//            guarantees that a pending inquiry is eventually served.
// Revision : 1.0 - initial release
// ============================================================================
module memory_access_scheduler #(
    parameter int ROWINDEXBITS = 7,
    parameter int COLINDEXBITS = 5,
    parameter int CLEARCYCLES  = 2,
    parameter int STARVELIMIT  = 4
) (
    input  logic                    clock,
    input  logic                    resetN,
    input  logic                    start,
    input  logic                    writeValid,
    input  logic [ROWINDEXBITS-1:0] writeWordIndex,
    input  logic [COLINDEXBITS-1:0] writeLetterIndex,
    output logic                    writeReady,
    input  logic                    inquiryValid,
    input  logic [ROWINDEXBITS-1:0] inquiryWordIndex,
    input  logic [COLINDEXBITS-1:0] inquiryLetterIndex,
    output logic                    inquiryReady,
    input  logic                    storageReady,
    input  logic                    readReady,
    input  logic                    storedValue,
    output logic [ROWINDEXBITS-1:0] wordIndex,
    output logic [COLINDEXBITS-1:0] letterIndex,
    output logic                    newAddress,
    output logic                    inquiry,
    output logic                    readMemory,
    output logic                    clearMemory,
    output logic                    resultValid,
    output logic                    resultValue,
    output logic                    busy
);

    localparam int CLEARW = $clog2(CLEARCYCLES + 1);
    localparam int STARVEW = $clog2(STARVELIMIT + 1);
    localparam logic [CLEARW-1:0]  CLEARLAST = CLEARW'(CLEARCYCLES - 1);
    localparam logic [STARVEW-1:0] STARVEMAX = STARVEW'(STARVELIMIT);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEAR     = 3'd1,
        WAITREADY = 3'd2,
        RUN       = 3'd3,
        READWAIT  = 3'd4
    } state_t;

    state_t              state;
    state_t              nextState;
    logic [CLEARW-1:0]   clearCount;
    logic [STARVEW-1:0]  starveCount;
    logic                grantWindow;
    logic                atLimit;
    logic                writeGrant;
    logic                inquiryGrant;

    // Arbitration: writes win unless an inquiry has been starved to the limit
    assign grantWindow  = (state == RUN) && storageReady;
    assign atLimit      = (starveCount == STARVEMAX);
    assign inquiryReady = grantWindow && inquiryValid && (!writeValid || atLimit);
    assign writeReady   = grantWindow && !(inquiryValid && atLimit);
    assign writeGrant   = writeValid && writeReady;
    assign inquiryGrant = inquiryValid && inquiryReady;
    assign busy         = (state != IDLE);

    // State register
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode
    always_comb begin
        nextState = state;
        case (state)
            IDLE:      if (start)              nextState = CLEAR;
            CLEAR:     if (clearCount == '0)   nextState = WAITREADY;
            WAITREADY: if (storageReady)       nextState = RUN;
            RUN:       if (inquiryGrant)       nextState = READWAIT;
            READWAIT:  if (readReady)          nextState = RUN;
            default:                           nextState = IDLE;
        endcase
    end

    // Clear-phase length counter, loaded as the sequence starts
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            clearCount <= '0;
        end else if (state == IDLE && start) begin
            clearCount <= CLEARLAST;
        end else if (state == CLEAR && clearCount != '0) begin
            clearCount <= clearCount - 1'b1;
        end
    end

    // Starvation counter: counts writes that overtook a waiting inquiry
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            starveCount <= '0;
        end else if (!inquiryValid || inquiryGrant) begin
            starveCount <= '0;
        end else if (writeGrant && !atLimit) begin
            starveCount <= starveCount + 1'b1;
        end
    end

    // Registered storage strobes, indices and inquiry result
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            wordIndex   <= '0;
            letterIndex <= '0;
            newAddress  <= 1'b0;
            inquiry     <= 1'b0;
            readMemory  <= 1'b0;
            clearMemory <= 1'b0;
            resultValid <= 1'b0;
            resultValue <= 1'b0;
        end else begin
            newAddress  <= writeGrant;
            inquiry     <= inquiryGrant;
            readMemory  <= inquiryGrant;
            clearMemory <= (nextState == CLEAR);
            resultValid <= 1'b0;
            if (writeGrant) begin
                wordIndex   <= writeWordIndex;
                letterIndex <= writeLetterIndex;
            end else if (inquiryGrant) begin
                wordIndex   <= inquiryWordIndex;
                letterIndex <= inquiryLetterIndex;
            end
            if (state == READWAIT && readReady) begin
                resultValid <= 1'b1;
                resultValue <= storedValue;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_access_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_access_scheduler
// Purpose  : Directed self-checking bench for memory_access_scheduler
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_access_scheduler;

    logic       clock = 1'b0;
    logic       resetN = 1'b1;
    logic       start = 1'b0;
    logic       writeValid = 1'b0;
    logic [6:0] writeWordIndex = '0;
    logic [4:0] writeLetterIndex = '0;
    logic       writeReady;
    logic       inquiryValid = 1'b0;
    logic [6:0] inquiryWordIndex = '0;
    logic [4:0] inquiryLetterIndex = '0;
    logic       inquiryReady;
    logic       storageReady = 1'b0;
    logic       readReady = 1'b0;
    logic       storedValue = 1'b0;
    logic [6:0] wordIndex;
    logic [4:0] letterIndex;
    logic       newAddress;
    logic       inquiry;
    logic       readMemory;
    logic       clearMemory;
    logic       resultValid;
    logic       resultValue;
    logic       busy;

    int checks = 0;
    int passes = 0;

    memory_access_scheduler #(
        .ROWINDEXBITS(7),
        .COLINDEXBITS(5),
        .CLEARCYCLES(2),
        .STARVELIMIT(4)
    ) dut (
        .clock(clock),
        .resetN(resetN),
        .start(start),
        .writeValid(writeValid),
        .writeWordIndex(writeWordIndex),
        .writeLetterIndex(writeLetterIndex),
        .writeReady(writeReady),
        .inquiryValid(inquiryValid),
        .inquiryWordIndex(inquiryWordIndex),
        .inquiryLetterIndex(inquiryLetterIndex),
        .inquiryReady(inquiryReady),
        .storageReady(storageReady),
        .readReady(readReady),
        .storedValue(storedValue),
        .wordIndex(wordIndex),
        .letterIndex(letterIndex),
        .newAddress(newAddress),
        .inquiry(inquiry),
        .readMemory(readMemory),
        .clearMemory(clearMemory),
        .resultValid(resultValid),
        .resultValue(resultValue),
        .busy(busy)
    );

    always #5 clock = ~clock;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #1 resetN = 1'b0;
        #1;
        checks++; if ({busy, clearMemory, newAddress, inquiry, readMemory, resultValid, resultValue} !== 7'b0) $display("FAIL reset_strobes got %b want 0000000", {busy, clearMemory, newAddress, inquiry, readMemory, resultValid, resultValue}); else passes++;
        checks++; if ({wordIndex, letterIndex} !== 12'h000) $display("FAIL reset_indices got %h want 000", {wordIndex, letterIndex}); else passes++;
        tick();
        tick();
        resetN = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) $display("FAIL idle_busy got %b want 0", busy); else passes++;
    endtask

    task automatic test_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if ({clearMemory, busy} !== 2'b11) $display("FAIL clear_c1 got %b want 11", {clearMemory, busy}); else passes++;
        tick();
        checks++; if (clearMemory !== 1'b1) $display("FAIL clear_c2 got %b want 1", clearMemory); else passes++;
        tick();
        checks++; if ({clearMemory, busy} !== 2'b01) $display("FAIL clear_end got %b want 01", {clearMemory, busy}); else passes++;
        // WAITREADY with storage not ready: nothing is granted
        writeValid = 1'b1;
        inquiryValid = 1'b1;
        #1;
        checks++; if ({writeReady, inquiryReady} !== 2'b00) $display("FAIL waitready_ready got %b want 00", {writeReady, inquiryReady}); else passes++;
        tick();
        tick();
        checks++; if ({newAddress, inquiry} !== 2'b00) $display("FAIL waitready_strobes got %b want 00", {newAddress, inquiry}); else passes++;
        writeValid = 1'b0;
        inquiryValid = 1'b0;
    endtask

    task automatic test_writes();
        storageReady = 1'b1;
        tick();
        writeValid = 1'b1;
        writeWordIndex = 7'd3;
        writeLetterIndex = 5'd5;
        #1;
        checks++; if ({writeReady, inquiryReady} !== 2'b10) $display("FAIL run_ready got %b want 10", {writeReady, inquiryReady}); else passes++;
        tick();
        checks++; if ({newAddress, wordIndex, letterIndex} !== {1'b1, 7'd3, 5'd5}) $display("FAIL write0 got %h want %h", {newAddress, wordIndex, letterIndex}, {1'b1, 7'd3, 5'd5}); else passes++;
        writeWordIndex = 7'd4;
        writeLetterIndex = 5'd0;
        tick();
        checks++; if ({newAddress, wordIndex, letterIndex} !== {1'b1, 7'd4, 5'd0}) $display("FAIL write1 got %h want %h", {newAddress, wordIndex, letterIndex}, {1'b1, 7'd4, 5'd0}); else passes++;
        writeValid = 1'b0;
        tick();
        checks++; if ({newAddress, wordIndex, letterIndex} !== {1'b0, 7'd4, 5'd0}) $display("FAIL write_hold got %h want %h", {newAddress, wordIndex, letterIndex}, {1'b0, 7'd4, 5'd0}); else passes++;
    endtask

    task automatic test_inquiry();
        inquiryValid = 1'b1;
        inquiryWordIndex = 7'd10;
        inquiryLetterIndex = 5'd2;
        #1;
        checks++; if (inquiryReady !== 1'b1) $display("FAIL inq_ready got %b want 1", inquiryReady); else passes++;
        tick();
        inquiryValid = 1'b0;
        writeValid = 1'b1;
        #1;
        checks++; if ({inquiry, readMemory, newAddress, wordIndex, letterIndex} !== {3'b110, 7'd10, 5'd2}) $display("FAIL inq_strobe got %h want %h", {inquiry, readMemory, newAddress, wordIndex, letterIndex}, {3'b110, 7'd10, 5'd2}); else passes++;
        checks++; if ({writeReady, inquiryReady} !== 2'b00) $display("FAIL readwait_ready got %b want 00", {writeReady, inquiryReady}); else passes++;
        tick();
        checks++; if ({inquiry, readMemory, newAddress, resultValid} !== 4'b0000) $display("FAIL readwait_idle got %b want 0000", {inquiry, readMemory, newAddress, resultValid}); else passes++;
        tick();
        writeValid = 1'b0;
        readReady = 1'b1;
        storedValue = 1'b1;
        tick();
        readReady = 1'b0;
        storedValue = 1'b0;
        checks++; if ({resultValid, resultValue, newAddress} !== 3'b110) $display("FAIL result got %b want 110", {resultValid, resultValue, newAddress}); else passes++;
        tick();
        checks++; if (resultValid !== 1'b0) $display("FAIL result_pulse got %b want 0", resultValid); else passes++;
    endtask

    task automatic test_starvation();
        writeValid = 1'b1;
        writeWordIndex = 7'd1;
        writeLetterIndex = 5'd1;
        inquiryValid = 1'b1;
        inquiryWordIndex = 7'd7;
        inquiryLetterIndex = 5'd1;
        for (int round = 0; round < 2; round++) begin
            for (int w = 0; w < 4; w++) begin
                #1;
                checks++; if ({writeReady, inquiryReady} !== 2'b10) $display("FAIL starve_r%0d_w%0d_ready got %b want 10", round, w, {writeReady, inquiryReady}); else passes++;
                tick();
                checks++; if (newAddress !== 1'b1) $display("FAIL starve_r%0d_w%0d_newAddress got %b want 1", round, w, newAddress); else passes++;
            end
            #1;
            checks++; if ({writeReady, inquiryReady} !== 2'b01) $display("FAIL starve_r%0d_limit got %b want 01", round, {writeReady, inquiryReady}); else passes++;
            tick();
            checks++; if ({inquiry, newAddress, wordIndex} !== {2'b10, 7'd7}) $display("FAIL starve_r%0d_inq got %h want %h", round, {inquiry, newAddress, wordIndex}, {2'b10, 7'd7}); else passes++;
            readReady = 1'b1;
            tick();
            readReady = 1'b0;
            checks++; if ({resultValid, resultValue} !== 2'b10) $display("FAIL starve_r%0d_result got %b want 10", round, {resultValid, resultValue}); else passes++;
        end
        writeValid = 1'b0;
        inquiryValid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        writeValid = 1'b1;
        inquiryValid = 1'b1;
        #1;
        checks++; if ({writeReady, inquiryReady} !== 2'b10) $display("FAIL simul_ready got %b want 10", {writeReady, inquiryReady}); else passes++;
        tick();
        checks++; if ({newAddress, inquiry} !== 2'b10) $display("FAIL simul_write got %b want 10", {newAddress, inquiry}); else passes++;
        writeValid = 1'b0;
        #1;
        checks++; if (inquiryReady !== 1'b1) $display("FAIL simul_inq_ready got %b want 1", inquiryReady); else passes++;
        tick();
        inquiryValid = 1'b0;
        checks++; if ({inquiry, readMemory, newAddress} !== 3'b110) $display("FAIL simul_inq got %b want 110", {inquiry, readMemory, newAddress}); else passes++;
    endtask

    task automatic test_reset_readwait();
        // Still in READWAIT from the previous scenario
        resetN = 1'b0;
        readReady = 1'b1;
        storedValue = 1'b1;
        #1;
        checks++; if ({busy, inquiry, readMemory, newAddress, clearMemory, resultValid, resultValue} !== 7'b0) $display("FAIL rst_rw_strobes got %b want 0000000", {busy, inquiry, readMemory, newAddress, clearMemory, resultValid, resultValue}); else passes++;
        checks++; if ({wordIndex, letterIndex} !== 12'h000) $display("FAIL rst_rw_indices got %h want 000", {wordIndex, letterIndex}); else passes++;
        tick();
        resetN = 1'b1;
        tick();
        tick();
        readReady = 1'b0;
        storedValue = 1'b0;
        checks++; if ({resultValid, busy, clearMemory} !== 3'b000) $display("FAIL rst_rw_after got %b want 000", {resultValid, busy, clearMemory}); else passes++;
        writeValid = 1'b1;
        #1;
        checks++; if (writeReady !== 1'b0) $display("FAIL rst_rw_idle_ready got %b want 0", writeReady); else passes++;
        writeValid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if ({clearMemory, busy} !== 2'b11) $display("FAIL rst_rw_restart got %b want 11", {clearMemory, busy}); else passes++;
    endtask

    initial begin
        test_reset();
        test_clear();
        test_writes();
        test_inquiry();
        test_starvation();
        test_back_to_back();
        test_reset_readwait();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Guard against a stuck simulation
    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
